// File: rtl/thro_offset_gen.sv
// rtl/thro_offset_gen.sv - throttle to four per-motor base offsets
// Deadband, Q4.4 gain, per-motor trim, clamp and per-clock slew limit.
module thro_offset_gen #(
  parameter logic        [7:0] DEADBAND = 8'd8,
  parameter logic        [7:0] GAIN     = 8'd16,
  parameter logic signed [7:0] TRIM_1   = 8'sd0,
  parameter logic signed [7:0] TRIM_2   = 8'sd0,
  parameter logic signed [7:0] TRIM_3   = 8'sd0,
  parameter logic signed [7:0] TRIM_4   = 8'sd0,
  parameter logic        [7:0] MAX_OUT  = 8'd250,
  parameter logic        [7:0] SLEW     = 8'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] thro_rec_val,
  output logic [7:0] motor_1_offset,
  output logic [7:0] motor_2_offset,
  output logic [7:0] motor_3_offset,
  output logic [7:0] motor_4_offset
);

  logic [7:0]       thro_q;
  logic [15:0]      prod;
  logic [11:0]      scaled;
  logic             in_deadband;
  logic [3:0][7:0]  offs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) thro_q <= 8'd0;
    else     thro_q <= thro_rec_val;
  end

  assign prod        = {8'd0, thro_q} * {8'd0, GAIN};
  assign scaled      = 12'(prod >> 4);
  assign in_deadband = (thro_q < DEADBAND);

  for (genvar g = 0; g < 4; g++) begin : g_motor
    localparam logic signed [7:0] TRIM_N = (g == 0) ? TRIM_1 :
                                           (g == 1) ? TRIM_2 :
                                           (g == 2) ? TRIM_3 : TRIM_4;
    logic signed [13:0] sum;
    logic [7:0]         target;
    logic [8:0]         up_diff;
    logic [8:0]         dn_diff;
    logic [7:0]         out_d;
    logic [7:0]         out_q;

    assign sum = $signed({2'b00, scaled}) + $signed({{6{TRIM_N[7]}}, TRIM_N});

    always_comb begin
      target = sum[7:0];
      if (in_deadband)                          target = 8'd0;
      else if (sum < 14'sd0)                    target = 8'd0;
      else if (sum > $signed({6'd0, MAX_OUT}))  target = MAX_OUT;
    end

    // 9-bit differences keep the step decision free of wraparound
    assign up_diff = {1'b0, target} - {1'b0, out_q};
    assign dn_diff = {1'b0, out_q} - {1'b0, target};

    always_comb begin
      out_d = target;
      if (SLEW != 8'd0) begin
        if (out_q < target && up_diff > {1'b0, SLEW})      out_d = out_q + SLEW;
        else if (out_q > target && dn_diff > {1'b0, SLEW}) out_d = out_q - SLEW;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) out_q <= 8'd0;
      else     out_q <= out_d;
    end

    assign offs[g] = out_q;
  end

  assign motor_1_offset = offs[0];
  assign motor_2_offset = offs[1];
  assign motor_3_offset = offs[2];
  assign motor_4_offset = offs[3];

endmodule

// File: tb/tb_thro_offset_gen.sv
// tb/tb_thro_offset_gen.sv - bench for thro_offset_gen
// Three instances share the input: defaults, trimmed, and high gain without slew.
module tb_thro_offset_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] thro = 8'd0;

  logic [7:0] d1, d2, d3, d4;
  logic [7:0] t1, t2, t3, t4;
  logic [7:0] g1, g2, g3, g4;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  thro_offset_gen u_def (
    .clk(clk), .rst(rst), .thro_rec_val(thro),
    .motor_1_offset(d1), .motor_2_offset(d2),
    .motor_3_offset(d3), .motor_4_offset(d4)
  );

  thro_offset_gen #(.TRIM_1(-8'sd20), .TRIM_2(8'sd10)) u_trim (
    .clk(clk), .rst(rst), .thro_rec_val(thro),
    .motor_1_offset(t1), .motor_2_offset(t2),
    .motor_3_offset(t3), .motor_4_offset(t4)
  );

  thro_offset_gen #(.GAIN(8'd24), .SLEW(8'd0)) u_gain (
    .clk(clk), .rst(rst), .thro_rec_val(thro),
    .motor_1_offset(g1), .motor_2_offset(g2),
    .motor_3_offset(g3), .motor_4_offset(g4)
  );

  typedef struct {
    logic [7:0] thro;
    logic [7:0] d;
    logic [7:0] t1;
    logic [7:0] t2;
    logic [7:0] t3;
    logic [7:0] g;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_def(input string name, input logic [7:0] exp);
    chk({name, ".m1"}, d1, exp);
    chk({name, ".m2"}, d2, exp);
    chk({name, ".m3"}, d3, exp);
    chk({name, ".m4"}, d4, exp);
  endtask

  task automatic chk_all_zero(input string name);
    chk_def(name, 8'd0);
    chk({name, ".t1"}, t1, 8'd0);
    chk({name, ".t2"}, t2, 8'd0);
    chk({name, ".g1"}, g1, 8'd0);
    chk({name, ".g4"}, g4, 8'd0);
  endtask

  task automatic async_reset(input string name);
    #2 rst = 1'b1;
    #1 chk_all_zero(name);
    tick();
    chk_all_zero({name, "_held"});
    tick();
    #2 rst = 1'b0;
    #1;
  endtask

  logic [7:0] exp_v;
  logic [7:0] prev_in;

  initial begin
    // thro, default, trim m1, trim m2, trim m3/m4, gain
    vecs[0] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
    vecs[1] = '{8'd7,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
    vecs[2] = '{8'd8,   8'd8,   8'd0,   8'd18,  8'd8,   8'd12};
    vecs[3] = '{8'd15,  8'd15,  8'd0,   8'd25,  8'd15,  8'd22};
    vecs[4] = '{8'd30,  8'd30,  8'd10,  8'd40,  8'd30,  8'd45};
    vecs[5] = '{8'd100, 8'd100, 8'd80,  8'd110, 8'd100, 8'd150};
    vecs[6] = '{8'd200, 8'd200, 8'd180, 8'd210, 8'd200, 8'd250};
    vecs[7] = '{8'd245, 8'd245, 8'd225, 8'd250, 8'd245, 8'd250};
    vecs[8] = '{8'd255, 8'd250, 8'd235, 8'd250, 8'd250, 8'd250};

    #1 chk_all_zero("reset_state");
    tick();
    #2 rst = 1'b0;
    #1;

    // deadband: 0..7 never moves the outputs, 8 appears two clocks later
    for (int v = 0; v < 8; v++) begin
      thro = 8'(v);
      tick();
      chk_def("deadband", 8'd0);
    end
    thro = 8'd8;
    tick();
    chk_def("deadband_edge_lat1", 8'd0);
    tick();
    chk_def("deadband_edge_lat2", 8'd8);

    // ramp: output follows the input delayed by two clocks
    thro = 8'd0;
    repeat (3) tick();
    chk_def("ramp_start", 8'd0);
    prev_in = 8'd0;
    for (int i = 0; i <= 40; i++) begin
      thro = 8'(i);
      tick();
      exp_v = (prev_in >= 8'd8) ? prev_in : 8'd0;
      chk_def("ramp", exp_v);
      prev_in = 8'(i);
    end
    tick();
    chk_def("ramp_final", 8'd40);

    // slew up from 8 to the clamp, then down, then reset mid-ramp
    thro = 8'd8;
    repeat (8) tick();
    chk_def("slew_base", 8'd8);
    thro = 8'd255;
    tick();
    chk_def("slew_sample", 8'd8);
    exp_v = 8'd8;
    for (int i = 0; i < 35; i++) begin
      exp_v = (exp_v > 8'd242) ? 8'd250 : exp_v + 8'd8;
      tick();
      chk_def("slew_up", exp_v);
    end
    thro = 8'd0;
    tick();
    chk_def("slew_dn_sample", 8'd250);
    for (int i = 0; i < 3; i++) begin
      exp_v = exp_v - 8'd8;
      tick();
      chk_def("slew_dn", exp_v);
    end
    async_reset("reset_mid_ramp");

    // thro 100 for 20 clocks, then reset between edges
    thro = 8'd100;
    repeat (20) tick();
    chk_def("steady_100", 8'd100);
    chk("gain_100", g1, 8'd150);
    async_reset("reset_steady");

    // settled values across all three parameter sets
    for (int k = 0; k < 9; k++) begin
      thro = vecs[k].thro;
      repeat (40) tick();
      chk_def($sformatf("vec%0d.def", k), vecs[k].d);
      chk($sformatf("vec%0d.trim1", k), t1, vecs[k].t1);
      chk($sformatf("vec%0d.trim2", k), t2, vecs[k].t2);
      chk($sformatf("vec%0d.trim3", k), t3, vecs[k].t3);
      chk($sformatf("vec%0d.trim4", k), t4, vecs[k].t3);
      chk($sformatf("vec%0d.gain1", k), g1, vecs[k].g);
      chk($sformatf("vec%0d.gain2", k), g2, vecs[k].g);
      chk($sformatf("vec%0d.gain3", k), g3, vecs[k].g);
      chk($sformatf("vec%0d.gain4", k), g4, vecs[k].g);
    end

    // zero slew: full step two clocks after the input change
    thro = 8'd100;
    tick();
    chk("gain_step_lat1", g1, 8'd250);
    tick();
    chk("gain_step_lat2", g1, 8'd150);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
